// File: rtl/dcmi_pkg.sv
// Shared types and constants for the DCMI byte-stream transmitter:
// FSM state encoding, inter-frame gap length and default sizing.
package dcmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int GAP_CYCLES     = 2;
  localparam int DEF_DEPTH_LOG2 = 6;
  localparam int DEF_FRAME_LEN  = 32;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with show-ahead registered read data, occupancy
// count and full/empty flags. A push while full is accepted only with a pop.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [7:0]            dout_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign full        = (count_reg == DEPTH_CNT);
  assign empty       = (count_reg == '0);
  assign pop_ok      = pop && !empty;
  assign push_ok     = push && (!full || pop_ok);
  assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign count       = count_reg;
  assign dout        = dout_reg;

  // Storage and read port carry no reset so they map onto block RAM.
  // The read address is the next head, with a bypass when that slot is
  // being written in the same cycle, so dout always shows the head byte.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      dout_reg <= din;
    end else begin
      dout_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dcmi_stream_tx.sv
// Buffers bytes from the IO port and replays them as DCMI frames paced by CLKEN.
// Define DCMI_STREAM_TX_CHECKSUM_EN to append a mod-256 payload sum to each frame.
module dcmi_stream_tx
  import dcmi_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [7:0] DI,
  input  logic       WR,
  input  logic       FLUSH,
  input  logic       CLKEN,
  output logic [7:0] DATA,
  output logic       DSYNC,
  output logic       FULL,
  output logic       BUSY,
  output logic       OVF
);

  localparam logic [DEPTH_LOG2:0] FRAME_CNT = (DEPTH_LOG2 + 1)'(FRAME_LEN);
  localparam logic [1:0]          GAP_LAST  = 2'(GAP_CYCLES - 1);

  state_t              state_reg;
  logic [7:0]          data_reg;
  logic                dsync_reg;
  logic                busy_reg;
  logic                ovf_reg;
  logic                flush_pend_reg;
  logic [DEPTH_LOG2:0] remain_reg;
  logic [1:0]          gap_cnt_reg;
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
  logic [7:0]          sum_reg;
  logic                csum_done_reg;
`endif

  logic [7:0]          fifo_dout;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                start_ok;
  logic                start_go;
  logic [DEPTH_LOG2:0] start_len;
  logic                pop;
  logic                drop;

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .Clk   (CLK),
    .rst_n (nRST),
    .push  (WR),
    .pop   (pop),
    .din   (DI),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start_ok  = (fifo_count >= FRAME_CNT) || (flush_pend_reg && !fifo_empty);
  assign start_go  = CLKEN && (state_reg == ST_IDLE) && start_ok;
  assign start_len = (fifo_count >= FRAME_CNT) ? FRAME_CNT : fifo_count;
  assign pop       = start_go ||
                     (CLKEN && ((state_reg == ST_START) || (state_reg == ST_SEND)) &&
                      (remain_reg != '0));
  assign drop      = WR && fifo_full && !pop;

  assign DATA  = data_reg;
  assign DSYNC = dsync_reg;
  assign BUSY  = busy_reg;
  assign FULL  = fifo_full;
  assign OVF   = ovf_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= ST_IDLE;
      data_reg       <= '0;
      dsync_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      flush_pend_reg <= 1'b0;
      remain_reg     <= '0;
      gap_cnt_reg    <= '0;
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
      sum_reg        <= '0;
      csum_done_reg  <= 1'b0;
`endif
    end else begin
      // A dropped byte outranks a simultaneous flush so the loss stays visible.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (FLUSH) begin
        ovf_reg <= 1'b0;
      end

      // A fresh strobe in the START cycle belongs to the next frame.
      if (FLUSH) begin
        flush_pend_reg <= 1'b1;
      end else if (start_go) begin
        flush_pend_reg <= 1'b0;
      end

      if (CLKEN) begin
        case (state_reg)
          ST_IDLE: begin
            if (start_ok) begin
              state_reg  <= ST_START;
              data_reg   <= fifo_dout;
              dsync_reg  <= 1'b1;
              busy_reg   <= 1'b1;
              remain_reg <= start_len - 1'b1;
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
              sum_reg       <= fifo_dout;
              csum_done_reg <= 1'b0;
`endif
            end
          end
          ST_START, ST_SEND: begin
            if (remain_reg != '0) begin
              state_reg  <= ST_SEND;
              data_reg   <= fifo_dout;
              remain_reg <= remain_reg - 1'b1;
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
              sum_reg    <= sum_reg + fifo_dout;
`endif
            end
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
            else if (!csum_done_reg) begin
              state_reg     <= ST_SEND;
              data_reg      <= sum_reg;
              csum_done_reg <= 1'b1;
            end
`endif
            else begin
              state_reg   <= ST_GAP;
              data_reg    <= '0;
              dsync_reg   <= 1'b0;
              gap_cnt_reg <= '0;
            end
          end
          ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            dsync_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcmi_stream_tx.sv
// Directed bench for dcmi_stream_tx: a 64-deep/4-byte-frame instance for the
// framing, flush, reset and streaming cases, and a 4-deep one for overflow.
module tb_dcmi_stream_tx;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] DI = 8'h00;
  logic       WR = 1'b0;
  logic       FLUSH = 1'b0;
  logic       CLKEN = 1'b0;
  logic [7:0] DATA;
  logic       DSYNC, FULL, BUSY, OVF;

  logic       b_wr = 1'b0;
  logic       b_flush = 1'b0;
  logic       b_clken = 1'b0;
  logic [7:0] b_data;
  logic       b_dsync, b_full, b_busy, b_ovf;

  int checks = 0;
  int errors = 0;
  int got, gap, idx, frames;
  logic [7:0] run_sum;

  always #5 CLK = ~CLK;

  dcmi_stream_tx #(.DEPTH_LOG2(6), .FRAME_LEN(4)) dut_a (
    .CLK(CLK), .nRST(nRST), .DI(DI), .WR(WR), .FLUSH(FLUSH), .CLKEN(CLKEN),
    .DATA(DATA), .DSYNC(DSYNC), .FULL(FULL), .BUSY(BUSY), .OVF(OVF)
  );

  dcmi_stream_tx #(.DEPTH_LOG2(2), .FRAME_LEN(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .DI(DI), .WR(b_wr), .FLUSH(b_flush), .CLKEN(b_clken),
    .DATA(b_data), .DSYNC(b_dsync), .FULL(b_full), .BUSY(b_busy), .OVF(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    DI = b; WR = 1'b1; cyc(); WR = 1'b0;
  endtask

  task automatic ce();
    CLKEN = 1'b1; cyc(); CLKEN = 1'b0;
  endtask

  task automatic flush();
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
  endtask

  // Expects a frame starting on the next CLKEN, followed by the gap and idle.
  task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int n, input logic [7:0] csum, input string tag);
    logic [7:0] bytes [4];
    bytes = '{b0, b1, b2, b3};
    for (int i = 0; i < n; i++) begin
      ce();
      check({tag, "_data"}, DATA, bytes[i]);
      check({tag, "_dsync"}, DSYNC, 1'b1);
      cyc();
      check({tag, "_hold"}, DATA, bytes[i]);
    end
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
    ce();
    check({tag, "_csum"}, DATA, csum);
    check({tag, "_csum_dsync"}, DSYNC, 1'b1);
`else
    if (csum === 8'hxx) $display("no checksum byte");
`endif
    ce();
    check({tag, "_gap1_dsync"}, DSYNC, 1'b0);
    check({tag, "_gap1_data"}, DATA, 8'h00);
    check({tag, "_gap1_busy"}, BUSY, 1'b1);
    ce();
    check({tag, "_gap2_dsync"}, DSYNC, 1'b0);
    check({tag, "_gap2_busy"}, BUSY, 1'b1);
    ce();
    check({tag, "_idle_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    check("rst_data", DATA, 8'h00);
    check("rst_dsync", DSYNC, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_full", FULL, 1'b0);
    check("rst_ovf", OVF, 1'b0);
    check("rst_b_full", b_full, 1'b0);
    nRST = 1'b1;
    cyc();

    // Full-length frame
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03); wr_byte(8'h04);
    check("f1_wait_busy", BUSY, 1'b0);
    expect_frame(8'h01, 8'h02, 8'h03, 8'h04, 4, 8'h0A, "f1");

    // Short frame on flush
    wr_byte(8'hAA); wr_byte(8'hBB);
    flush();
    check("f2_pend", dut_a.flush_pend_reg, 1'b1);
    check("f2_wait_busy", BUSY, 1'b0);
    expect_frame(8'hAA, 8'hBB, 8'h00, 8'h00, 2, 8'h65, "f2");
    check("f2_pend_clr", dut_a.flush_pend_reg, 1'b0);

    // Flush on empty FIFO stays pending until data arrives
    flush();
    ce();
    check("f3_empty_busy", BUSY, 1'b0);
    check("f3_pend", dut_a.flush_pend_reg, 1'b1);
    wr_byte(8'h55);
    expect_frame(8'h55, 8'h00, 8'h00, 8'h00, 1, 8'h55, "f3");
    check("f3_pend_clr", dut_a.flush_pend_reg, 1'b0);

    wr_byte(8'h10); wr_byte(8'h20); wr_byte(8'h30); wr_byte(8'h40);
    expect_frame(8'h10, 8'h20, 8'h30, 8'h40, 4, 8'hA0, "f4");

    // Flush during a frame applies after the gap
    wr_byte(8'hE1); wr_byte(8'hE2); wr_byte(8'hE3); wr_byte(8'hE4); wr_byte(8'hE5);
    ce();
    check("f5_first", DATA, 8'hE1);
    flush();
    check("f5_pend", dut_a.flush_pend_reg, 1'b1);
    repeat (3) ce();
    check("f5_last", DATA, 8'hE4);
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
    ce();
`endif
    repeat (3) ce();
    check("f5_gap_done", BUSY, 1'b0);
    check("f5_pend_kept", dut_a.flush_pend_reg, 1'b1);
    expect_frame(8'hE5, 8'h00, 8'h00, 8'h00, 1, 8'hE5, "f6");

    // Reset in the middle of a frame
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    ce(); ce(); ce();
    check("rm_third", DATA, 8'h33);
    #2 nRST = 1'b0;
    #1;
    check("rm_data", DATA, 8'h00);
    check("rm_dsync", DSYNC, 1'b0);
    check("rm_busy", BUSY, 1'b0);
    cyc();
    nRST = 1'b1;
    cyc();
    check("rm_count", dut_a.u_fifo.count_reg, 0);
    flush();
    ce();
    check("rm_empty_busy", BUSY, 1'b0);
    nRST = 1'b0; cyc(); nRST = 1'b1; cyc();

    // Overflow on the 4-deep instance
    for (int i = 0; i < 4; i++) begin
      DI = 8'hC0 + 8'(i); b_wr = 1'b1; cyc(); b_wr = 1'b0;
    end
    check("ov_full", b_full, 1'b1);
    check("ov_ovf0", b_ovf, 1'b0);
    DI = 8'hC4; b_wr = 1'b1; cyc(); b_wr = 1'b0;
    check("ov_ovf1", b_ovf, 1'b1);
    check("ov_full2", b_full, 1'b1);
    b_flush = 1'b1; cyc(); b_flush = 1'b0;
    check("ov_clr", b_ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b_clken = 1'b1; cyc(); b_clken = 1'b0;
      check("ov_data", b_data, 8'hC0 + 8'(i));
    end
    b_clken = 1'b1; cyc(); b_clken = 1'b0;
`ifdef DCMI_STREAM_TX_CHECKSUM_EN
    check("ov_csum", b_data, 8'h06);
`else
    check("ov_no5th", b_dsync, 1'b0);
`endif

    // Continuous writes while frames stream out
    got = 0; gap = 0; idx = 0; frames = 0; run_sum = 8'h00;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          DI = 8'h80 + 8'(i); WR = 1'b1; cyc();
        end
        WR = 1'b0;
      end
      begin
        for (int p = 0; p < 80; p++) begin
          ce();
          if (DSYNC) begin
            if (gap > 0) begin
              if (frames > 0) check("st_gap_min", 32'(gap >= 2), 1);
              frames++;
              idx = 0;
              run_sum = 8'h00;
            end
            if (idx < 4) begin
              check("st_byte", DATA, 8'h80 + 8'(got));
              run_sum = run_sum + DATA;
              got++;
            end else begin
              check("st_csum", DATA, run_sum);
            end
            idx++;
            gap = 0;
          end else begin
            gap++;
          end
          cyc(); cyc();
        end
      end
    join
    check("st_count", got, 20);
    check("st_frames", frames, 5);
    check("st_ovf", OVF, 1'b0);
    check("st_busy", BUSY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcmi_stream_tx.md
DCMI_STREAM_TX -- requirements
Module: dcmi_stream_tx

Interface
REQ-001 Parameter DEPTH_LOG2, default 6: FIFO depth is 2**DEPTH_LOG2 bytes.
REQ-002 Parameter FRAME_LEN, default 32: payload bytes per frame; legal range 1..2**DEPTH_LOG2.
REQ-003 CLK  in  1  single system clock; all logic is on its rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 DI  in  8  byte from the IO port DO output.
REQ-006 WR  in  1  one-cycle strobe that pushes DI into the FIFO.
REQ-007 FLUSH  in  1  one-cycle strobe requesting transmission of a short final frame.
REQ-008 CLKEN  in  1  DCMI pixel-clock enable pulse from the DCMI clock generator.
REQ-009 DATA  out  8  DCMI data; forced to 0 when not driving, so it can be wired-OR onto the bus.
REQ-010 DSYNC  out  1  frame-valid; forced to 0 when idle.
REQ-011 FULL  out  1  FIFO full.
REQ-012 BUSY  out  1  a frame is in progress.
REQ-013 OVF  out  1  sticky overflow flag.

Function
REQ-014 A WR while FULL=0 shall store DI in the FIFO; a WR while FULL=1 shall drop the byte and set OVF.
REQ-015 OVF shall clear only on reset or on a FLUSH strobe.
REQ-016 The FSM shall have states IDLE, START, SEND and GAP, and shall advance only on cycles where CLKEN=1.
REQ-017 IDLE->START shall occur when FIFO count >= FRAME_LEN, or when a flush is pending and count > 0.
REQ-018 A FLUSH strobe shall set the pending flag; the flag shall clear when START is entered.
REQ-019 A FLUSH strobe with an empty FIFO shall not start a frame; the pending flag stays set.
REQ-020 On entering START, the frame length shall be latched as min(count, FRAME_LEN).
REQ-021 START shall last one CLKEN period with DSYNC=1 and DATA equal to the first byte.
REQ-022 SEND shall pop one byte per CLKEN and hold DATA/DSYNC stable between CLKEN pulses.
REQ-023 After the last byte the FSM shall enter GAP.
REQ-024 GAP shall last 2 CLKEN periods with DSYNC=0 and DATA=0, then return to IDLE.
REQ-025 BUSY shall be 1 in START, SEND and GAP.
REQ-026 DATA/DSYNC shall be registered outputs.
REQ-027 Bytes shall be transmitted in the order written; the FIFO pointers shall wrap modulo 2**DEPTH_LOG2.
REQ-028 A count of DEPTH_LOG2+1 bits shall track occupancy.
REQ-029 A simultaneous WR and pop in one cycle shall leave the count unchanged; the push shall still succeed when FULL=1 in that cycle.
REQ-030 A FLUSH strobe during a frame shall be latched and applied after GAP.

Reset
REQ-031 nRST=0 shall asynchronously force: state IDLE, FIFO empty, DATA=0, DSYNC=0, BUSY=0, FULL=0, OVF=0, flush pending 0.
REQ-032 A reset asserted mid-frame shall abort the frame immediately and discard all FIFO contents.

Configuration
REQ-033 Macro DCMI_STREAM_TX_CHECKSUM_EN, when defined, shall append one byte after the payload, inside DSYNC=1, before GAP.
REQ-034 The appended byte shall be the sum of the frame's payload bytes mod 256.
REQ-035 When DCMI_STREAM_TX_CHECKSUM_EN is undefined, no byte is appended and no summing logic is present.

Structure
REQ-036 Package dcmi_pkg shall hold the FSM state encoding, GAP_CYCLES=2 and the default DEPTH_LOG2/FRAME_LEN constants.
REQ-037 Storage shall be a sub-module byte_fifo (synchronous, single clock, count/full/empty outputs).
REQ-038 The FSM, the flush latch and the checksum shall reside in dcmi_stream_tx.

Verification
REQ-039 Scenario: FRAME_LEN=4, write 01 02 03 04 -> one frame with DSYNC high for 4 CLKENs, DATA 01,02,03,04, then 2 idle CLKENs.
REQ-040 Scenario: write AA BB, then FLUSH -> 2-byte frame AA,BB; flush pending then 0.
REQ-041 Scenario: DEPTH_LOG2=2, write 5 bytes with no CLKEN -> FULL=1, 5th byte dropped, OVF=1; FLUSH clears OVF.
REQ-042 Scenario: checksum enabled, frame 10 20 30 40 -> 5th byte A0 while DSYNC=1.
REQ-043 Scenario: nRST low during the 3rd byte -> DATA=0 and DSYNC=0 at once; FIFO empty after release.
REQ-044 Scenario: WR every cycle during a frame with a 64-deep FIFO -> no OVF, back-to-back frames separated by 2-CLKEN gaps, byte order intact.
